// File: rtl/sgmii_tx_sched.sv
// sgmii_tx_sched: chooses one byte per clock for the 8b10b encoder.
// Schedules /I2/ idle sets, /C1/ /C2/ auto-negotiation sets and framed packets
// (/S/, preamble, SFD, payload, pad, /T/, /R/), keeping ordered sets even-aligned.
module sgmii_tx_sched #(
  parameter int unsigned MIN_PAYLOAD = 60,
  parameter int unsigned IFG_SETS    = 6
) (
  input  logic        sgmii_clk_in,
  input  logic        reset,
  input  logic        an_mode,
  input  logic [15:0] an_config,
  input  logic        pkt_valid,
  input  logic [7:0]  pkt_data,
  input  logic        pkt_last,
  output logic        pkt_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_is_k,
  output logic        tx_even,
  output logic        busy,
  output logic        underrun
);

  localparam int unsigned    IfgW   = $clog2(IFG_SETS + 1);
  localparam logic [IfgW-1:0] IfgMax = IfgW'(IFG_SETS);
  localparam logic [15:0]    MinCnt = 16'(MIN_PAYLOAD);

  typedef enum logic [3:0] {
    StIdleK, StIdleD, StCfgK, StCfgId, StCfgLo, StCfgHi,
    StSop, StPre, StSfd, StData, StPad, StEot, StExt
  } state_e;

  state_e          state_q, state_d;
  logic [IfgW-1:0] ifg_q, ifg_d;
  logic [15:0]     cnt_q, cnt_d, cnt_inc;
  logic [2:0]      pre_q, pre_d;
  logic            c2_q, c2_d;
  logic [15:0]     cfg_q, cfg_d;
  logic            underrun_q, underrun_d;
  logic [7:0]      tx_byte_q, byte_d;
  logic            tx_is_k_q, k_d;
  logic            tx_even_q;
  logic            busy_q, busy_d;
  logic            boundary;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Next-state, chosen byte and side-state updates for the byte chosen this cycle.
  always_comb begin
    state_d    = state_q;
    ifg_d      = ifg_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    c2_d       = c2_q;
    cfg_d      = cfg_q;
    underrun_d = underrun_q;
    byte_d     = 8'h00;
    k_d        = 1'b0;
    pkt_ready  = 1'b0;
    boundary   = 1'b0;
    unique case (state_q)
      StIdleK: begin
        byte_d  = 8'hBC;
        k_d     = 1'b1;
        state_d = StIdleD;
      end
      StIdleD: begin
        byte_d   = 8'h50;
        ifg_d    = (ifg_q == IfgMax) ? ifg_q : ifg_q + 1'b1;
        boundary = 1'b1;
      end
      StCfgK: begin
        byte_d  = 8'hBC;
        k_d     = 1'b1;
        cfg_d   = an_config;
        state_d = StCfgId;
      end
      StCfgId: begin
        byte_d  = c2_q ? 8'h42 : 8'hB5;
        state_d = StCfgLo;
      end
      StCfgLo: begin
        byte_d  = cfg_q[7:0];
        state_d = StCfgHi;
      end
      StCfgHi: begin
        byte_d   = cfg_q[15:8];
        c2_d     = ~c2_q;
        boundary = 1'b1;
        // Leaving config: a packet may start without an idle gap.
        if (!an_mode) ifg_d = IfgMax;
      end
      StSop: begin
        byte_d  = 8'hFB;
        k_d     = 1'b1;
        ifg_d   = '0;
        cnt_d   = '0;
        pre_d   = '0;
        state_d = StPre;
      end
      StPre: begin
        byte_d = 8'h55;
        pre_d  = pre_q + 3'd1;
        if (pre_q == 3'd5) state_d = StSfd;
      end
      StSfd: begin
        byte_d  = 8'hD5;
        state_d = StData;
      end
      StData: begin
        pkt_ready = 1'b1;
        if (pkt_valid) begin
          byte_d = pkt_data;
          cnt_d  = cnt_inc;
          if (pkt_last) state_d = (cnt_inc < MinCnt) ? StPad : StEot;
        end else begin
          // Starved: send /V/ and keep waiting for payload.
          byte_d     = 8'hFE;
          k_d        = 1'b1;
          underrun_d = 1'b1;
        end
      end
      StPad: begin
        byte_d = 8'h00;
        cnt_d  = cnt_inc;
        if (cnt_inc >= MinCnt) state_d = StEot;
      end
      StEot: begin
        byte_d  = 8'hFD;
        k_d     = 1'b1;
        state_d = StExt;
      end
      StExt: begin
        byte_d = 8'hF7;
        k_d    = 1'b1;
        // tx_even_q high means this /R/ lands on an odd slot, so the next set starts even.
        if (tx_even_q) boundary = 1'b1;
      end
      default: state_d = StIdleK;
    endcase
    if (!(state_q inside {StCfgK, StCfgId, StCfgLo, StCfgHi})) c2_d = 1'b0;
    if (boundary) begin
      if (an_mode)                            state_d = StCfgK;
      else if (pkt_valid && (ifg_d >= IfgMax)) state_d = StSop;
      else                                    state_d = StIdleK;
    end
    busy_d = state_q inside {StSop, StPre, StSfd, StData, StPad, StEot, StExt};
  end

  // State and registered outputs; synchronous reset abandons any frame or set.
  always_ff @(posedge sgmii_clk_in) begin
    if (reset) begin
      state_q    <= StIdleK;
      ifg_q      <= '0;
      cnt_q      <= '0;
      pre_q      <= '0;
      c2_q       <= 1'b0;
      cfg_q      <= '0;
      underrun_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_is_k_q  <= 1'b0;
      tx_even_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ifg_q      <= ifg_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      c2_q       <= c2_d;
      cfg_q      <= cfg_d;
      underrun_q <= underrun_d;
      tx_byte_q  <= byte_d;
      tx_is_k_q  <= k_d;
      tx_even_q  <= ~tx_even_q;
      busy_q     <= busy_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_is_k  = tx_is_k_q;
  assign tx_even  = tx_even_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_sgmii_tx_sched.sv
// tb_sgmii_tx_sched: random frames and config sets checked against a byte-stream model
// built from the framing rules (idle gap, preamble, pad to minimum, /R/ parity).
module tb_sgmii_tx_sched;

  localparam int MinPay = 60;

  logic        clk = 1'b0;
  logic        reset, an_mode, pkt_valid, pkt_last;
  logic [15:0] an_config;
  logic [7:0]  pkt_data, tx_byte;
  logic        pkt_ready, tx_is_k, tx_even, busy, underrun;

  int checks = 0;
  int failures = 0;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] b;
    logic       k;
    logic       f;     // inside a frame (busy)
    logic       slot;  // byte chosen while payload is being accepted
  } ent_t;

  ent_t        exp_q[$];
  logic [7:0]  pay_q[$];
  logic        last_q[$];
  int          cyc, acc_cnt, gap_after, gap_left, an_on_at, an_off_at, cfg_chg_at;
  logic [15:0] cfg_new;

  sgmii_tx_sched #(.MIN_PAYLOAD(60), .IFG_SETS(6)) dut (
    .sgmii_clk_in(clk),
    .reset       (reset),
    .an_mode     (an_mode),
    .an_config   (an_config),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .pkt_last    (pkt_last),
    .pkt_ready   (pkt_ready),
    .tx_byte     (tx_byte),
    .tx_is_k     (tx_is_k),
    .tx_even     (tx_even),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference stream model ----------------
  function automatic void push(input logic [7:0] b, input logic k, input logic f,
                               input logic slot);
    ent_t e;
    e.b = b; e.k = k; e.f = f; e.slot = slot;
    exp_q.push_back(e);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      push(8'hBC, 1'b1, 1'b0, 1'b0);
      push(8'h50, 1'b0, 1'b0, 1'b0);
    end
  endfunction

  function automatic void push_cfg(input int s, input logic [15:0] val);
    push(8'hBC, 1'b1, 1'b0, 1'b0);
    push((s % 2 == 1) ? 8'h42 : 8'hB5, 1'b0, 1'b0, 1'b0);
    push(val[7:0], 1'b0, 1'b0, 1'b0);
    push(val[15:8], 1'b0, 1'b0, 1'b0);
  endfunction

  // Frame on the wire: /S/ 55x6 D5 payload (with /V/ during gaps) pad /T/ then /R/
  // so that /S/../R/ has even length.
  function automatic void push_frame(input bq_t d, input int gap_at, input int gap_n);
    int total;
    int pad;
    pad = (d.size() < MinPay) ? MinPay - d.size() : 0;
    push(8'hFB, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) push(8'h55, 1'b0, 1'b1, 1'b0);
    push(8'hD5, 1'b0, 1'b1, 1'b0);
    total = 8;
    for (int i = 0; i < d.size(); i++) begin
      push(d[i], 1'b0, 1'b1, 1'b1);
      total++;
      if (i + 1 == gap_at)
        for (int g = 0; g < gap_n; g++) begin
          push(8'hFE, 1'b1, 1'b1, 1'b1);
          total++;
        end
    end
    for (int i = 0; i < pad; i++) begin
      push(8'h00, 1'b0, 1'b1, 1'b0);
      total++;
    end
    push(8'hFD, 1'b1, 1'b1, 1'b0);
    total++;
    push(8'hF7, 1'b1, 1'b1, 1'b0);
    if (total % 2 == 0) push(8'hF7, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic void queue_frame(input bq_t d);
    for (int i = 0; i < d.size(); i++) begin
      pay_q.push_back(d[i]);
      last_q.push_back(i == d.size() - 1);
    end
  endfunction

  function automatic bq_t rand_frame(input int len);
    bq_t d;
    for (int i = 0; i < len; i++) d.push_back(8'($urandom_range(0, 255)));
    return d;
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic do_reset(input int n);
    reset = 1'b1; an_mode = 1'b0; an_config = 16'h0000;
    pkt_valid = 1'b0; pkt_last = 1'b0; pkt_data = 8'h00;
    pay_q.delete(); last_q.delete(); exp_q.delete();
    cyc = 0; acc_cnt = 0; gap_after = -1; gap_left = 0;
    an_on_at = 1 << 30; an_off_at = 1 << 30; cfg_chg_at = -1; cfg_new = 16'h0000;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive inputs that the DUT uses to choose byte idx, then wait until it is visible.
  task automatic tick(output int idx, output logic rdy);
    idx = cyc;
    an_mode = (cyc >= an_on_at) && (cyc < an_off_at);
    if (cyc == cfg_chg_at) an_config = cfg_new;
    if (gap_left > 0 && acc_cnt == gap_after) begin
      pkt_valid = 1'b0;
      gap_left--;
    end else if (pay_q.size() > 0) begin
      pkt_valid = 1'b1; pkt_data = pay_q[0]; pkt_last = last_q[0];
    end else begin
      pkt_valid = 1'b0; pkt_last = 1'b0;
    end
    rdy = pkt_ready;
    if (pkt_valid && pkt_ready) begin
      acc_cnt = last_q[0] ? 0 : acc_cnt + 1;
      void'(pay_q.pop_front());
      void'(last_q.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int idx; logic rdy, ev; ent_t e;
    do_reset(3);
    checks++;
    if ({tx_byte, tx_is_k, tx_even, busy, pkt_ready, underrun} !== 13'h0) begin
      failures++;
      $display("FAIL reset_vals got byte=%h k=%b ev=%b busy=%b rdy=%b und=%b need all 0",
               tx_byte, tx_is_k, tx_even, busy, pkt_ready, underrun);
    end
    push_idle(12);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(idx, rdy);
      e = exp_q[idx]; ev = (idx % 2 == 0);
      checks++;
      if ({tx_byte, tx_is_k, tx_even, busy, rdy} !== {e.b, e.k, ev, e.f, e.slot}) begin
        failures++;
        $display("FAIL idle idx=%0d got %h/%b/%b/%b/%b need %h/%b/%b/%b/%b", idx, tx_byte,
                 tx_is_k, tx_even, busy, rdy, e.b, e.k, ev, e.f, e.slot);
      end
    end
  endtask

  task automatic test_short_frame();
    int idx, busy_cnt; logic rdy, ev; ent_t e; bq_t d;
    do_reset(2);
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    queue_frame(d);
    push_idle(6); push_frame(d, -1, 0); push_idle(3);
    busy_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(idx, rdy);
      e = exp_q[idx]; ev = (idx % 2 == 0);
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if ({tx_byte, tx_is_k, tx_even, busy, rdy} !== {e.b, e.k, ev, e.f, e.slot}) begin
        failures++;
        $display("FAIL short idx=%0d got %h/%b/%b/%b/%b need %h/%b/%b/%b/%b", idx, tx_byte,
                 tx_is_k, tx_even, busy, rdy, e.b, e.k, ev, e.f, e.slot);
      end
    end
    checks++;
    if (busy_cnt != 70) begin
      failures++;
      $display("FAIL short_busy_len got %0d need 70", busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int idx; logic rdy, ev; ent_t e; bq_t d;
    int lens[5];
    lens = '{61, $urandom_range(1, 100), 59, 60, 1};
    do_reset(2);
    foreach (lens[f]) begin
      d = rand_frame(lens[f]);
      queue_frame(d);
      push_idle(6);
      push_frame(d, -1, 0);
    end
    push_idle(3);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(idx, rdy);
      e = exp_q[idx]; ev = (idx % 2 == 0);
      checks++;
      if ({tx_byte, tx_is_k, tx_even, busy, rdy} !== {e.b, e.k, ev, e.f, e.slot}) begin
        failures++;
        $display("FAIL b2b idx=%0d got %h/%b/%b/%b/%b need %h/%b/%b/%b/%b", idx, tx_byte,
                 tx_is_k, tx_even, busy, rdy, e.b, e.k, ev, e.f, e.slot);
      end
    end
  endtask

  task automatic test_config();
    int idx; logic rdy, ev; ent_t e; bq_t d;
    do_reset(2);
    an_config  = 16'h4001;
    an_on_at   = 0;
    cfg_new    = 16'h4020;
    cfg_chg_at = 11 + int'($urandom_range(0, 2));  // inside the third set
    an_off_at  = 23 + int'($urandom_range(0, 2));  // inside the sixth set
    d = rand_frame($urandom_range(1, 10));
    queue_frame(d);
    push_idle(1);
    for (int s = 0; s < 6; s++)
      push_cfg(s, (exp_q.size() >= cfg_chg_at) ? cfg_new : 16'h4001);
    push_frame(d, -1, 0);  // leaving config needs no idle gap
    push_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(idx, rdy);
      e = exp_q[idx]; ev = (idx % 2 == 0);
      checks++;
      if ({tx_byte, tx_is_k, tx_even, busy, rdy} !== {e.b, e.k, ev, e.f, e.slot}) begin
        failures++;
        $display("FAIL config idx=%0d got %h/%b/%b/%b/%b need %h/%b/%b/%b/%b", idx, tx_byte,
                 tx_is_k, tx_even, busy, rdy, e.b, e.k, ev, e.f, e.slot);
      end
    end
  endtask

  task automatic test_underrun();
    int idx; logic rdy, ev, und; ent_t e; bq_t d;
    do_reset(2);
    d = rand_frame(20);
    queue_frame(d);
    gap_after = 10;
    gap_left  = 2;
    push_idle(6); push_frame(d, 10, 2); push_idle(3);
    und = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(idx, rdy);
      e = exp_q[idx]; ev = (idx % 2 == 0);
      if (e.b == 8'hFE && e.k) und = 1'b1;
      checks++;
      if ({tx_byte, tx_is_k, tx_even, busy, rdy, underrun} !==
          {e.b, e.k, ev, e.f, e.slot, und}) begin
        failures++;
        $display("FAIL underrun idx=%0d got %h/%b/%b/%b/%b/%b need %h/%b/%b/%b/%b/%b", idx,
                 tx_byte, tx_is_k, tx_even, busy, rdy, underrun, e.b, e.k, ev, e.f, e.slot, und);
      end
    end
  endtask

  task automatic test_preempt();
    int idx; logic rdy, ev; ent_t e; bq_t d;
    do_reset(2);
    an_config = 16'h1234;
    an_on_at  = 14 + int'($urandom_range(0, 3));  // while preamble is being chosen
    d = rand_frame($urandom_range(1, 70));
    queue_frame(d);
    push_idle(6); push_frame(d, -1, 0);
    for (int s = 0; s < 3; s++) push_cfg(s, 16'h1234);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(idx, rdy);
      e = exp_q[idx]; ev = (idx % 2 == 0);
      checks++;
      if ({tx_byte, tx_is_k, tx_even, busy, rdy} !== {e.b, e.k, ev, e.f, e.slot}) begin
        failures++;
        $display("FAIL preempt idx=%0d got %h/%b/%b/%b/%b need %h/%b/%b/%b/%b", idx, tx_byte,
                 tx_is_k, tx_even, busy, rdy, e.b, e.k, ev, e.f, e.slot);
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx, sop_idx; logic rdy, ev; ent_t e; bq_t d;
    do_reset(2);
    d = rand_frame(40);
    queue_frame(d);
    push_idle(6); push_frame(d, -1, 0);
    for (int i = 0; i < 35; i++) begin  // stop partway through the payload
      tick(idx, rdy);
      e = exp_q[idx]; ev = (idx % 2 == 0);
      checks++;
      if ({tx_byte, tx_is_k, tx_even, busy, rdy} !== {e.b, e.k, ev, e.f, e.slot}) begin
        failures++;
        $display("FAIL rst_mid_pre idx=%0d got %h/%b/%b/%b/%b need %h/%b/%b/%b/%b", idx,
                 tx_byte, tx_is_k, tx_even, busy, rdy, e.b, e.k, ev, e.f, e.slot);
      end
    end
    do_reset(1);
    checks++;
    if ({tx_byte, tx_is_k, tx_even, busy, pkt_ready, underrun} !== 13'h0) begin
      failures++;
      $display("FAIL rst_mid_zero got byte=%h k=%b ev=%b busy=%b rdy=%b und=%b need all 0",
               tx_byte, tx_is_k, tx_even, busy, pkt_ready, underrun);
    end
    d = rand_frame(5);
    queue_frame(d);
    push_idle(6); push_frame(d, -1, 0); push_idle(1);
    sop_idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick(idx, rdy);
      e = exp_q[idx]; ev = (idx % 2 == 0);
      if (sop_idx < 0 && tx_byte === 8'hFB && tx_is_k === 1'b1) sop_idx = idx;
      checks++;
      if ({tx_byte, tx_is_k, tx_even, busy, rdy} !== {e.b, e.k, ev, e.f, e.slot}) begin
        failures++;
        $display("FAIL rst_mid_post idx=%0d got %h/%b/%b/%b/%b need %h/%b/%b/%b/%b", idx,
                 tx_byte, tx_is_k, tx_even, busy, rdy, e.b, e.k, ev, e.f, e.slot);
      end
    end
    checks++;
    if (sop_idx != 12) begin
      failures++;
      $display("FAIL rst_mid_gap first /S/ at byte %0d need 12", sop_idx);
    end
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_back_to_back();
    test_config();
    test_underrun();
    test_preempt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
